ls_issue_queue: RTL and testbench

- In-order load/store issue queue sitting between dispatch and the memory execution unit.
- Buffers LW/SW instructions and snoops the CDB to capture missing operand values.
- Issues the oldest entry once its operands are ready and, for loads, once a CDB slot is granted.
- Drives the memory execution unit's issue fields (issueblk_done, issueque_*).

---
 rtl/ls_issue_queue.sv | 137 +++++++++++++
 tb/tb_ls_issue_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: buffers LW/SW from dispatch, snoops the CDB for
// missing operands, and hands the oldest ready entry to the memory execution unit.
module ls_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic             dispatch_opcode,
  input  logic [31:0]      dispatch_rs_data,
  input  logic [TAG_W-1:0] dispatch_rs_tag,
  input  logic             dispatch_rs_valid,
  input  logic [31:0]      dispatch_rt_data,
  input  logic [TAG_W-1:0] dispatch_rt_tag,
  input  logic             dispatch_rt_valid,
  input  logic [31:0]      dispatch_imm,
  input  logic [TAG_W-1:0] dispatch_rd_tag,
  output logic             queue_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             issue_ready,
  output logic             issueblk_done,
  output logic             issueque_opcode,
  output logic [31:0]      issueque_rs_data,
  output logic [31:0]      issueque_rt_data,
  output logic [31:0]      issueque_imm,
  output logic [TAG_W-1:0] issueque_rd_tag
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             valid;
    logic             opcode;
    logic [31:0]      rs_data;
    logic [TAG_W-1:0] rs_tag;
    logic             rs_rdy;
    logic [31:0]      rt_data;
    logic [TAG_W-1:0] rt_tag;
    logic             rt_rdy;
    logic [31:0]      imm;
    logic [TAG_W-1:0] rd_tag;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             head_e, new_e;
  logic               push, pop, head_ok;

  assign queue_full = (count_q == CNT_W'(DEPTH));
  assign head_e     = ent_q[head_q];
  assign head_ok    = head_e.valid && head_e.rs_rdy && head_e.rt_rdy;
  assign pop        = head_ok && (head_e.opcode || issue_ready) && !flush;
  assign push       = dispatch_valid && !queue_full && !flush;

  assign issueblk_done    = pop;
  assign issueque_opcode  = head_e.valid ? head_e.opcode  : 1'b0;
  assign issueque_rs_data = head_e.valid ? head_e.rs_data : '0;
  assign issueque_rt_data = head_e.valid ? head_e.rt_data : '0;
  assign issueque_imm     = head_e.valid ? head_e.imm     : '0;
  assign issueque_rd_tag  = head_e.valid ? head_e.rd_tag  : '0;

  // New entry, including capture of an operand broadcast on the CDB in the dispatch cycle.
  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.opcode  = dispatch_opcode;
    new_e.rs_data = dispatch_rs_data;
    new_e.rs_tag  = dispatch_rs_tag;
    new_e.rs_rdy  = dispatch_rs_valid;
    new_e.rt_data = dispatch_rt_data;
    new_e.rt_tag  = dispatch_rt_tag;
    new_e.rt_rdy  = !dispatch_opcode || dispatch_rt_valid;
    new_e.imm     = dispatch_imm;
    new_e.rd_tag  = dispatch_rd_tag;
    if (!new_e.rs_rdy && cdb_valid && cdb_tag == dispatch_rs_tag) begin
      new_e.rs_data = cdb_data;
      new_e.rs_rdy  = 1'b1;
    end
    if (!new_e.rt_rdy && cdb_valid && cdb_tag == dispatch_rt_tag) begin
      new_e.rt_data = cdb_data;
      new_e.rt_rdy  = 1'b1;
    end
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && cdb_valid) begin
        if (!ent_q[i].rs_rdy && ent_q[i].rs_tag == cdb_tag) begin
          ent_d[i].rs_data = cdb_data;
          ent_d[i].rs_rdy  = 1'b1;
        end
        if (!ent_q[i].rt_rdy && ent_q[i].rt_tag == cdb_tag) begin
          ent_d[i].rt_data = cdb_data;
          ent_d[i].rt_rdy  = 1'b1;
        end
      end
    end
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end
    // Pop and push never hit the same slot: a push needs a free slot, so tail != head.
    if (push) begin
      ent_d[tail_q] = new_e;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (flush) begin
      ent_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed bench for ls_issue_queue; expected issues are queued at dispatch and
// compared in order whenever the queue reports an issue.
module tb_ls_issue_queue;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             dispatch_valid, dispatch_opcode, dispatch_rs_valid, dispatch_rt_valid;
  logic [31:0]      dispatch_rs_data, dispatch_rt_data, dispatch_imm;
  logic [TAG_W-1:0] dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag;
  logic             queue_full;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_ready;
  logic             issueblk_done, issueque_opcode;
  logic [31:0]      issueque_rs_data, issueque_rt_data, issueque_imm;
  logic [TAG_W-1:0] issueque_rd_tag;

  typedef struct {
    logic             op;
    logic [31:0]      rs, rt, imm;
    logic [TAG_W-1:0] rd;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  ls_issue_queue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
    .dispatch_rs_data(dispatch_rs_data), .dispatch_rs_tag(dispatch_rs_tag),
    .dispatch_rs_valid(dispatch_rs_valid), .dispatch_rt_data(dispatch_rt_data),
    .dispatch_rt_tag(dispatch_rt_tag), .dispatch_rt_valid(dispatch_rt_valid),
    .dispatch_imm(dispatch_imm), .dispatch_rd_tag(dispatch_rd_tag),
    .queue_full(queue_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .issue_ready(issue_ready), .issueblk_done(issueblk_done),
    .issueque_opcode(issueque_opcode), .issueque_rs_data(issueque_rs_data),
    .issueque_rt_data(issueque_rt_data), .issueque_imm(issueque_imm),
    .issueque_rd_tag(issueque_rd_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dispatch_valid = 0; dispatch_opcode = 0; dispatch_rs_valid = 0; dispatch_rt_valid = 0;
    dispatch_rs_data = 0; dispatch_rt_data = 0; dispatch_imm = 0;
    dispatch_rs_tag = 0; dispatch_rt_tag = 0; dispatch_rd_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0;
  endtask

  // Drive a dispatch; push=1 queues the expected issue record.
  task automatic disp(input logic op, input logic [31:0] rs, input logic [TAG_W-1:0] rstag,
                      input logic rsv, input logic [31:0] rt, input logic [TAG_W-1:0] rttag,
                      input logic rtv, input logic [31:0] imm, input logic [TAG_W-1:0] rd,
                      input logic push, input logic [31:0] exp_rs, input logic [31:0] exp_rt);
    exp_t e;
    dispatch_valid = 1; dispatch_opcode = op;
    dispatch_rs_data = rs; dispatch_rs_tag = rstag; dispatch_rs_valid = rsv;
    dispatch_rt_data = rt; dispatch_rt_tag = rttag; dispatch_rt_valid = rtv;
    dispatch_imm = imm; dispatch_rd_tag = rd;
    if (push) begin
      e.op = op; e.rs = exp_rs; e.rt = exp_rt; e.imm = imm; e.rd = rd;
      sb.push_back(e);
    end
  endtask

  task automatic ldr(input logic [31:0] rs, input logic [TAG_W-1:0] rd, input logic push);
    disp(1'b0, rs, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 32'h4, rd, push, rs, 32'h0);
  endtask

  // One clock: check issue outputs before the edge, then return at the next negedge.
  task automatic cyc(input logic exp_done, input string tag);
    exp_t e;
    #1;
    chk({tag, ".done"}, 32'(issueblk_done), 32'(exp_done));
    if (issueblk_done === 1'b1) begin
      if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk({tag, ".op"},  32'(issueque_opcode), 32'(e.op));
        chk({tag, ".rs"},  issueque_rs_data, e.rs);
        if (e.op) chk({tag, ".rt"}, issueque_rt_data, e.rt);
        chk({tag, ".imm"}, issueque_imm, e.imm);
        chk({tag, ".rd"},  32'(issueque_rd_tag), 32'(e.rd));
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1; issue_ready = 0; idle();
    #2;
    chk("rst.full", 32'(queue_full), 0);
    chk("rst.done", 32'(issueblk_done), 0);
    chk("rst.rs", issueque_rs_data, 0);
    @(negedge clk); rst = 0;

    // Reset mid-operation
    ldr(32'hA1, 6'd1, 1'b1); cyc(0, "mid0");
    ldr(32'hA2, 6'd2, 1'b1); cyc(0, "mid1");
    ldr(32'hA3, 6'd3, 1'b1); cyc(0, "mid2");
    chk("mid.head_rs", issueque_rs_data, 32'hA1);
    #2 rst = 1; sb.delete();
    #1;
    chk("mid.full", 32'(queue_full), 0);
    chk("mid.done", 32'(issueblk_done), 0);
    chk("mid.rs", issueque_rs_data, 0);
    chk("mid.rd", 32'(issueque_rd_tag), 0);
    @(negedge clk); rst = 0;

    // Ready LW into empty queue
    issue_ready = 1;
    ldr(32'h10, 6'd5, 1'b1); cyc(0, "lw.disp");
    cyc(1, "lw.iss");
    chk("lw.empty_rs", issueque_rs_data, 0);
    cyc(0, "lw.after");

    // SW waiting on rt via CDB, issue_ready low throughout
    issue_ready = 0;
    disp(1'b1, 32'h100, 6'd0, 1'b1, 32'h0, 6'd9, 1'b0, 32'h8, 6'd0, 1'b1, 32'h100, 32'hDEAD);
    cyc(0, "sw.disp");
    cyc(0, "sw.wait");
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'hDEAD; cyc(0, "sw.cdb");
    cyc(1, "sw.iss");

    // Non-ready head LW blocks younger ready SW
    issue_ready = 1;
    disp(1'b0, 32'h0, 6'd3, 1'b0, 32'h0, 6'd0, 1'b0, 32'hC, 6'd12, 1'b1, 32'h200, 32'h0);
    cyc(0, "ord.lw");
    disp(1'b1, 32'h300, 6'd0, 1'b1, 32'h77, 6'd0, 1'b1, 32'h10, 6'd0, 1'b1, 32'h300, 32'h77);
    cyc(0, "ord.sw");
    cyc(0, "ord.wait");
    cdb_valid = 1; cdb_tag = 6'd3; cdb_data = 32'h200; cyc(0, "ord.cdb");
    cyc(1, "ord.iss_lw");
    cyc(1, "ord.iss_sw");

    // Operand captured from CDB in the dispatch cycle
    disp(1'b0, 32'h0, 6'd7, 1'b0, 32'h0, 6'd0, 1'b0, 32'h4, 6'd8, 1'b1, 32'h300, 32'h0);
    cdb_valid = 1; cdb_tag = 6'd7; cdb_data = 32'h300; cyc(0, "cap.disp");
    cyc(1, "cap.iss");

    // Fill to full; tail wraps 3 -> 0 along the way
    issue_ready = 0;
    ldr(32'h1, 6'd1, 1'b1); cyc(0, "full.d1");
    ldr(32'h2, 6'd2, 1'b1); cyc(0, "full.d2");
    ldr(32'h3, 6'd3, 1'b1); cyc(0, "full.d3");
    ldr(32'h4, 6'd4, 1'b1); cyc(0, "full.d4");
    chk("full.flag", 32'(queue_full), 1);
    ldr(32'h55, 6'd9, 1'b0); cyc(0, "full.drop");
    chk("full.flag2", 32'(queue_full), 1);
    issue_ready = 1;
    ldr(32'h56, 6'd9, 1'b0); cyc(1, "full.pop_rej");
    chk("full.after_pop", 32'(queue_full), 0);
    ldr(32'h6, 6'd6, 1'b1); cyc(1, "full.pop_push");
    issue_ready = 0;
    ldr(32'h7, 6'd7, 1'b1); cyc(0, "full.refill");
    chk("full.count_kept", 32'(queue_full), 1);
    issue_ready = 1;
    cyc(1, "drain3"); cyc(1, "drain4"); cyc(1, "drain6"); cyc(1, "drain7");
    cyc(0, "drain.empty");

    // Flush with a simultaneous dispatch
    issue_ready = 0;
    ldr(32'hF1, 6'd1, 1'b1); cyc(0, "fl.d1");
    ldr(32'hF2, 6'd2, 1'b1); cyc(0, "fl.d2");
    ldr(32'hF3, 6'd3, 1'b1); cyc(0, "fl.d3");
    issue_ready = 1; flush = 1; sb.delete();
    ldr(32'hF4, 6'd4, 1'b0); cyc(0, "fl.flush");
    chk("fl.rs", issueque_rs_data, 0);
    chk("fl.full", 32'(queue_full), 0);
    cyc(0, "fl.nostore");
    ldr(32'hE0, 6'd10, 1'b1); cyc(0, "fl.redisp");
    cyc(1, "fl.reiss");
    chk("end.sb", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
